fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the instruction decoder.
- Owns the program counter and drives a synchronous instruction memory. Presents the fetched 32-bit word on d_inst with a valid flag.
- Consumes the decoder's d_jump and d_a outputs to redirect the program counter.
- Freezes while the decoder is in program/bypass mode (d_prog).

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the instruction decoder.
//
// Owns the program counter and drives a synchronous instruction memory that
// has one cycle of read latency and holds its output while imem_en_o is low.
// The fetched word is registered onto d_inst_o. inst_valid_o marks it as a
// correct-path instruction. The decoder's jump decode (d_jump_i / d_a_i) is
// fed back here to redirect the PC. While the decoder is in program/bypass
// mode (d_prog_i) the stage parks in PROG and only accepts PC loads.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   en_i           run enable; low parks the stage in IDLE
//   stall_i        downstream hold; freezes pc, memory read and d_inst
//   d_prog_i       program/bypass mode shared with the decoder
//   d_jump_i       decoder jump decode for the current instruction
//   d_a_i          decoder address field, used as jump target
//   imem_addr_o    memory read address (equals pc_o)
//   imem_en_o      memory read enable
//   imem_rdata_i   memory read data, valid one cycle after imem_en_o
//   d_inst_o       registered instruction to the decoder
//   inst_valid_o   d_inst_o holds a correct-path instruction
//   pc_o           current program counter
//   state_o        debug state: IDLE=0, RUN=1, PROG=2
module fetch_unit #(
  parameter int unsigned PC_W     = 8,   // must not exceed the 16-bit d_a_i field
  parameter int unsigned INST_W   = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              stall_i,
  input  logic              d_prog_i,
  input  logic              d_jump_i,
  input  logic [15:0]       d_a_i,
  output logic [PC_W-1:0]   imem_addr_o,
  output logic              imem_en_o,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [INST_W-1:0] d_inst_o,
  output logic              inst_valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StProg = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INST_W-1:0]   d_inst_q, d_inst_d;
  logic                inst_valid_q, inst_valid_d;
  // imem_rdata_i carries a correct-path read (not one issued before a redirect)
  logic                rd_valid_q, rd_valid_d;
  logic                jump_taken;
  logic [PC_W-1:0]     jump_target;

  assign jump_target = d_a_i[PC_W-1:0];
  assign jump_taken  = (state_q == StRun) & inst_valid_q & d_jump_i & ~stall_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    d_inst_d     = d_inst_q;
    inst_valid_d = inst_valid_q;
    rd_valid_d   = rd_valid_q;

    if (d_prog_i) begin
      // Program mode wins over everything but reset; the pipeline is flushed.
      state_d      = StProg;
      rd_valid_d   = 1'b0;
      inst_valid_d = 1'b0;
      if ((state_q == StProg) && d_jump_i) begin
        pc_d = jump_target;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (en_i) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (!en_i) begin
            state_d      = StIdle;
            rd_valid_d   = 1'b0;
            inst_valid_d = 1'b0;
          end else if (stall_i) begin
            // Hold everything; the memory holds its data because imem_en_o is low.
          end else if (jump_taken) begin
            // The read in flight is for the fall-through path, so both
            // pipeline slots are marked invalid: two bubbles follow.
            pc_d         = jump_target;
            d_inst_d     = imem_rdata_i;
            inst_valid_d = 1'b0;
            rd_valid_d   = 1'b0;
          end else begin
            pc_d         = pc_q + PC_W'(1);
            d_inst_d     = imem_rdata_i;
            inst_valid_d = rd_valid_q;
            rd_valid_d   = 1'b1;
          end
        end
        StProg: begin
          state_d = en_i ? StRun : StIdle;
        end
        default: begin
          state_d      = StIdle;
          rd_valid_d   = 1'b0;
          inst_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      pc_q         <= PC_W'(RESET_PC);
      d_inst_q     <= '0;
      inst_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      d_inst_q     <= d_inst_d;
      inst_valid_q <= inst_valid_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign imem_en_o    = (state_q == StRun) & ~stall_i & ~d_prog_i & en_i;
  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign d_inst_o     = d_inst_q;
  assign inst_valid_o = inst_valid_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written reset/wrap
// sequences, and randomized stimulus checked against a queue-based model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, stall, d_prog, d_jump;
  logic [15:0] d_a;
  logic [7:0]  imem_addr, pc;
  logic        imem_en, inst_valid;
  logic [31:0] imem_rdata, d_inst;
  logic [1:0]  state;

  logic        en_w;
  logic [7:0]  w_addr, w_pc;
  logic        w_en, w_valid;
  logic [31:0] w_rdata, w_inst;
  logic [1:0]  w_state;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(8), .INST_W(32), .RESET_PC(0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .stall_i(stall), .d_prog_i(d_prog),
    .d_jump_i(d_jump), .d_a_i(d_a), .imem_addr_o(imem_addr), .imem_en_o(imem_en),
    .imem_rdata_i(imem_rdata), .d_inst_o(d_inst), .inst_valid_o(inst_valid),
    .pc_o(pc), .state_o(state)
  );

  fetch_unit #(.PC_W(8), .INST_W(32), .RESET_PC(254)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_w), .stall_i(1'b0), .d_prog_i(1'b0),
    .d_jump_i(1'b0), .d_a_i(16'h0000), .imem_addr_o(w_addr), .imem_en_o(w_en),
    .imem_rdata_i(w_rdata), .d_inst_o(w_inst), .inst_valid_o(w_valid),
    .pc_o(w_pc), .state_o(w_state)
  );

  // Synchronous memories: one-cycle latency, hold data when not enabled.
  initial begin
    imem_rdata = 32'h0;
    w_rdata    = 32'h0;
  end
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
    if (w_en)    w_rdata    <= mem[w_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        en, stall, prog, jump;
    logic [15:0] a;
    logic        ien;
    logic [1:0]  st;
    logic [7:0]  pc;
    logic        v;
    logic [31:0] inst;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic s, input logic p, input logic j,
                              input logic [15:0] a, input logic ien, input logic [1:0] st,
                              input logic [7:0] pcv, input logic v, input logic [31:0] inst);
    vec_t r;
    r.en = e; r.stall = s; r.prog = p; r.jump = j; r.a = a;
    r.ien = ien; r.st = st; r.pc = pcv; r.v = v; r.inst = inst;
    return r;
  endfunction

  // Reference model: counts issued correct-path reads in a queue and delivers
  // mem[addr] one advance later; a redirect discards everything in flight.
  int          m_mode;  // 0 idle, 1 run, 2 prog
  logic [7:0]  m_pc;
  logic [7:0]  m_q [$];
  logic        m_valid;
  logic [31:0] m_inst;

  task automatic model_reset();
    m_mode = 0; m_pc = 8'h00; m_q.delete(); m_valid = 1'b0; m_inst = 32'h0;
  endtask

  task automatic model_edge(input logic e, input logic s, input logic p, input logic j,
                            input logic [15:0] a);
    if (p) begin
      if (m_mode == 2 && j) m_pc = a[7:0];
      m_mode = 2; m_q.delete(); m_valid = 1'b0;
    end else if (m_mode == 2) begin
      m_mode = e ? 1 : 0;
    end else if (!e) begin
      m_mode = 0; m_q.delete(); m_valid = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (!s) begin
      logic take;
      take = m_valid && j;
      if (m_q.size() > 0) begin
        m_inst  = mem[m_q.pop_front()];
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (take) begin
        m_q.delete(); m_valid = 1'b0; m_pc = a[7:0];
      end else begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 8'd1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0; stall = 1'b0; d_prog = 1'b0; d_jump = 1'b0; d_a = 16'h0; en_w = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [30];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;

    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd1, 8'h00, 1'b0, 32'h0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h01, 1'b0, 32'h0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h02, 1'b1, 32'h1000_0000);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h03, 1'b1, 32'h1000_0001);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h04, 1'b1, 32'h1000_0002);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h05, 1'b1, 32'h1000_0003);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd1, 8'h05, 1'b1, 32'h1000_0003);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd1, 8'h05, 1'b1, 32'h1000_0003);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd1, 8'h05, 1'b1, 32'h1000_0003);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h06, 1'b1, 32'h1000_0004);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h07, 1'b1, 32'h1000_0005);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b1, 16'hFF40, 1'b1, 2'd1, 8'h40, 1'b0, 32'h0);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h41, 1'b0, 32'h0);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h42, 1'b1, 32'h1000_0040);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h43, 1'b1, 32'h1000_0041);
    tbl[15] = mk(1'b1, 1'b1, 1'b0, 1'b1, 16'h0080, 1'b0, 2'd1, 8'h43, 1'b1, 32'h1000_0041);
    tbl[16] = mk(1'b1, 1'b1, 1'b0, 1'b1, 16'h0080, 1'b0, 2'd1, 8'h43, 1'b1, 32'h1000_0041);
    tbl[17] = mk(1'b1, 1'b0, 1'b0, 1'b1, 16'h0080, 1'b1, 2'd1, 8'h80, 1'b0, 32'h0);
    tbl[18] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h81, 1'b0, 32'h0);
    tbl[19] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h82, 1'b1, 32'h1000_0080);
    tbl[20] = mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd2, 8'h82, 1'b0, 32'h0);
    tbl[21] = mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0012, 1'b0, 2'd2, 8'h12, 1'b0, 32'h0);
    tbl[22] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd1, 8'h12, 1'b0, 32'h0);
    tbl[23] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h13, 1'b0, 32'h0);
    tbl[24] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h14, 1'b1, 32'h1000_0012);
    tbl[25] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h14, 1'b0, 32'h0);
    tbl[26] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h14, 1'b0, 32'h0);
    tbl[27] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd1, 8'h14, 1'b0, 32'h0);
    tbl[28] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h15, 1'b0, 32'h0);
    tbl[29] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 8'h16, 1'b1, 32'h1000_0014);

    // Reset values, checked while reset is held.
    rst_n = 1'b1;
    en = 1'b1; stall = 1'b0; d_prog = 1'b0; d_jump = 1'b0; d_a = 16'h0; en_w = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_pc",    32'(pc), 32'h0);
    check("reset_state", 32'(state), 32'h0);
    check("reset_valid", 32'(inst_valid), 32'h0);
    check("reset_inst",  d_inst, 32'h0);
    check("reset_ien",   32'(imem_en), 32'h0);
    check("reset_wpc",   32'(w_pc), 32'h0000_00FE);
    do_reset();

    // Directed vector table.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      en = tbl[i].en; stall = tbl[i].stall; d_prog = tbl[i].prog;
      d_jump = tbl[i].jump; d_a = tbl[i].a;
      #1;
      check($sformatf("vec%0d_imem_en", i), 32'(imem_en), 32'(tbl[i].ien));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      check($sformatf("vec%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
      check($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(tbl[i].pc));
      check($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(tbl[i].v));
      if (tbl[i].v) check($sformatf("vec%0d_inst", i), d_inst, tbl[i].inst);
    end

    // PC wrap from RESET_PC=0xFE with continuous valid across the wrap.
    do_reset();
    @(negedge clk);
    en_w = 1'b1;
    @(posedge clk);
    #1;
    check("wrap_state", 32'(w_state), 32'h1);
    check("wrap_pc0", 32'(w_pc), 32'h0000_00FE);
    for (int k = 1; k <= 5; k++) begin
      logic [7:0] exp_pc, exp_a;
      exp_pc = 8'(254 + k);
      exp_a  = 8'(252 + k);
      @(posedge clk);
      #1;
      check($sformatf("wrap_pc%0d", k), 32'(w_pc), 32'(exp_pc));
      check($sformatf("wrap_valid%0d", k), 32'(w_valid), (k >= 2) ? 32'h1 : 32'h0);
      if (k >= 2) check($sformatf("wrap_inst%0d", k), w_inst, mem[exp_a]);
    end

    // Reset while stalled on a valid jump: nothing of the jump survives.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      en = 1'b1;
    end
    @(negedge clk);
    stall = 1'b1; d_jump = 1'b1; d_a = 16'h0080;
    @(posedge clk);
    #1;
    check("mid_stall_valid", 32'(inst_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pc",    32'(pc), 32'h0);
    check("mid_rst_state", 32'(state), 32'h0);
    check("mid_rst_valid", 32'(inst_valid), 32'h0);
    check("mid_rst_inst",  d_inst, 32'h0);
    check("mid_rst_ien",   32'(imem_en), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_pc0", 32'(pc), 32'h0);
    @(posedge clk);
    #1;
    check("post_rst_pc1", 32'(pc), 32'h1);

    // Randomized stimulus against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      logic exp_ien;
      @(negedge clk);
      d_prog = ($urandom_range(0, 15) == 0);
      en     = ($urandom_range(0, 15) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      d_jump = ($urandom_range(0, 5) == 0);
      d_a    = 16'($urandom);
      exp_ien = (m_mode == 1) && !stall && !d_prog && en;
      #1;
      check("rnd_imem_en", 32'(imem_en), 32'(exp_ien));
      @(posedge clk);
      #1;
      model_edge(en, stall, d_prog, d_jump, d_a);
      check("rnd_state", 32'(state), 32'(m_mode));
      check("rnd_pc", 32'(pc), 32'(m_pc));
      check("rnd_addr", 32'(imem_addr), 32'(m_pc));
      check("rnd_valid", 32'(inst_valid), 32'(m_valid));
      if (m_valid) check("rnd_inst", d_inst, m_inst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
